plc_seq_cfg_master: RTL and testbench
=====================================

PLC_SEQ_CFG_MASTER -- requirements
Module: plc_seq_cfg_master

Interface
REQ-001 Parameter NUM_REGS, default 4: number of consecutive 32-bit registers written, then read back.
REQ-002 Parameter BASE_ADDR, default 32'h0000_0000: byte address of register 0.
REQ-003 Parameter C_M_AXI_ADDR_WIDTH, default 32: address width.
REQ-004 ACLK  in  1  sole clock; all logic rising-edge.
REQ-005 ARESETN  in  1  reset, asynchronous assert, active-low.
REQ-006 start  in  1  one-cycle request to run a configure-and-verify sequence.
REQ-007 cfg_data  in  NUM_REGS*32  register values; register i is bits [32i+31:32i].
REQ-008 busy  out  1  sequence in progress.
REQ-009 done  out  1  one-cycle pulse at sequence end.
REQ-010 error  out  1  result of the last sequence; 1 = any failure.
REQ-011 err_index  out  8  index of the first failing register of the last sequence.
REQ-012 M_AXI_AWADDR/AWPROT/AWVALID out, AWREADY in  32/3/1/1  AXI4-Lite write address channel.
REQ-013 M_AXI_WDATA/WSTRB/WVALID out, WREADY in  32/4/1/1  AXI4-Lite write data channel.
REQ-014 M_AXI_BRESP/BVALID in, BREADY out  2/1/1  AXI4-Lite write response channel.
REQ-015 M_AXI_ARADDR/ARPROT/ARVALID out, ARREADY in  32/3/1/1  AXI4-Lite read address channel.
REQ-016 M_AXI_RDATA/RRESP/RVALID in, RREADY out  32/2/1/1  AXI4-Lite read data channel.

Function
REQ-017 FSM states: IDLE, WR_REQ, WR_RESP, RD_REQ, RD_RESP, FINISH.
REQ-018 IDLE: start=1 latches cfg_data into a snapshot, clears error/err_index, sets idx=0, enters WR_REQ; busy=1 from the next cycle.
REQ-019 start while busy=1 is ignored; the snapshot is unaffected.
REQ-020 WR_REQ: AWVALID and WVALID assert together with AWADDR=BASE_ADDR+4*idx, WDATA=snapshot[idx], WSTRB=4'hF, AWPROT=0.
REQ-021 AWVALID and WVALID each drop the cycle after their own handshake, independently; WR_RESP is entered once both have completed, in any order or in the same cycle.
REQ-022 WR_RESP: BREADY=1; on BVALID, BRESP!=OKAY is a failure for idx; if idx=NUM_REGS-1, go RD_REQ with idx=0, else idx+1 and WR_REQ.
REQ-023 RD_REQ: ARVALID=1, ARADDR=BASE_ADDR+4*idx, ARPROT=0; on ARREADY go RD_RESP.
REQ-024 RD_RESP: RREADY=1; on RVALID, RRESP!=OKAY or RDATA!=snapshot[idx] is a failure for idx; last idx goes to FINISH, else idx+1 and RD_REQ.
REQ-025 Only one outstanding transaction at any time; VALID once asserted stays high, with stable payload, until READY.
REQ-026 Failures do not abort; the full sequence always completes. error is sticky within a run; err_index records only the first failure.
REQ-027 FINISH: done=1 for exactly one cycle, busy=0 from the same cycle, return to IDLE; error/err_index hold until the next start.
REQ-028 Latency with zero-wait slave (READY/VALID responses in the cycle after request): 2 cycles per write, 2 per read, plus one FINISH cycle.

Reset
REQ-029 ARESETN=0 forces IDLE asynchronously, mid-transaction included; all VALID/READY outputs, busy, done, error = 0; err_index, idx, addresses, data = 0.
REQ-030 After release, no AXI activity until a new start; an aborted run is neither resumed nor reported.

Structure
REQ-031 Package plc_seq_cfg_pkg holds the FSM state enum and the AXI response constants (OKAY=2'b00, SLVERR=2'b10).
REQ-032 No sub-module: the single-transaction handshake logic stays inline in the FSM.

Verification
REQ-033 cfg_data={4,3,2,1} to a memory slave, start -> writes at 0x0,0x4,0x8,0xC, readback matches, done pulse, error=0.
REQ-034 Slave returns RDATA=0x5 for address 0x8 -> error=1, err_index=2, all 4 reads still issued.
REQ-035 BRESP=SLVERR on address 0x4 and read mismatch at 0xC -> error=1, err_index=1.
REQ-036 WREADY 3 cycles before AWREADY, and both in the same cycle -> exactly one B wait per write, no repeated VALID.
REQ-037 Second start during a run -> ignored; exactly 4 writes, 4 reads, one done.
REQ-038 ARESETN low during WR_REQ -> all VALIDs low immediately, busy=0; a fresh start completes normally.

Source files
------------

// File: rtl/plc_seq_cfg_pkg.sv
// Shared types for the configure-and-verify AXI4-Lite master: FSM states and
// AXI response codes.
package plc_seq_cfg_pkg;

    typedef enum logic [2:0] {
        ST_IDLE,
        ST_WR_REQ,
        ST_WR_RESP,
        ST_RD_REQ,
        ST_RD_RESP,
        ST_FINISH
    } state_e;

    localparam logic [1:0] RESP_OKAY   = 2'b00;
    localparam logic [1:0] RESP_SLVERR = 2'b10;

endpackage

// File: rtl/plc_seq_cfg_master.sv
// Writes NUM_REGS consecutive registers over AXI4-Lite, reads them back and
// reports the first register whose write response or readback failed.
module plc_seq_cfg_master
    import plc_seq_cfg_pkg::*;
#(
    parameter int                NUM_REGS           = 4,
    parameter logic [31:0]       BASE_ADDR          = 32'h0000_0000,
    parameter int                C_M_AXI_ADDR_WIDTH = 32
) (
    input  logic                          ACLK,
    input  logic                          ARESETN,
    input  logic                          start,
    input  logic [NUM_REGS*32-1:0]        cfg_data,
    output logic                          busy,
    output logic                          done,
    output logic                          error,
    output logic [7:0]                    err_index,
    output logic [C_M_AXI_ADDR_WIDTH-1:0] M_AXI_AWADDR,
    output logic [2:0]                    M_AXI_AWPROT,
    output logic                          M_AXI_AWVALID,
    input  logic                          M_AXI_AWREADY,
    output logic [31:0]                   M_AXI_WDATA,
    output logic [3:0]                    M_AXI_WSTRB,
    output logic                          M_AXI_WVALID,
    input  logic                          M_AXI_WREADY,
    input  logic [1:0]                    M_AXI_BRESP,
    input  logic                          M_AXI_BVALID,
    output logic                          M_AXI_BREADY,
    output logic [C_M_AXI_ADDR_WIDTH-1:0] M_AXI_ARADDR,
    output logic [2:0]                    M_AXI_ARPROT,
    output logic                          M_AXI_ARVALID,
    input  logic                          M_AXI_ARREADY,
    input  logic [31:0]                   M_AXI_RDATA,
    input  logic [1:0]                    M_AXI_RRESP,
    input  logic                          M_AXI_RVALID,
    output logic                          M_AXI_RREADY
);

    localparam int AW    = C_M_AXI_ADDR_WIDTH;
    localparam int IDX_W = (NUM_REGS > 1) ? $clog2(NUM_REGS) : 1;
    localparam logic [IDX_W-1:0] LAST_IDX = IDX_W'(NUM_REGS - 1);
    localparam logic [AW-1:0]    BASE     = AW'(BASE_ADDR);

    state_e           state_q, state_d;
    logic [IDX_W-1:0] idx_q, idx_d;
    logic [31:0]      snap_q [NUM_REGS];
    logic             aw_done_q, aw_done_d;
    logic             w_done_q, w_done_d;
    logic             error_q, error_d;
    logic [7:0]       err_idx_q, err_idx_d;
    logic             snap_load;
    logic             fail;
    logic [31:0]      cur_word;
    logic [AW-1:0]    cur_addr;

    assign cur_word = snap_q[idx_q];
    assign cur_addr = BASE + (AW'(idx_q) << 2);

    always_ff @(posedge ACLK or negedge ARESETN) begin
        if (!ARESETN) begin
            state_q   <= ST_IDLE;
            idx_q     <= '0;
            aw_done_q <= 1'b0;
            w_done_q  <= 1'b0;
            error_q   <= 1'b0;
            err_idx_q <= '0;
            for (int i = 0; i < NUM_REGS; i++) snap_q[i] <= '0;
        end else begin
            state_q   <= state_d;
            idx_q     <= idx_d;
            aw_done_q <= aw_done_d;
            w_done_q  <= w_done_d;
            error_q   <= error_d;
            err_idx_q <= err_idx_d;
            if (snap_load) begin
                for (int i = 0; i < NUM_REGS; i++) snap_q[i] <= cfg_data[32*i +: 32];
            end
        end
    end

    always_comb begin
        state_d       = state_q;
        idx_d         = idx_q;
        aw_done_d     = aw_done_q;
        w_done_d      = w_done_q;
        error_d       = error_q;
        err_idx_d     = err_idx_q;
        snap_load     = 1'b0;
        fail          = 1'b0;
        M_AXI_AWVALID = 1'b0;
        M_AXI_AWADDR  = '0;
        M_AXI_WVALID  = 1'b0;
        M_AXI_WDATA   = '0;
        M_AXI_WSTRB   = '0;
        M_AXI_BREADY  = 1'b0;
        M_AXI_ARVALID = 1'b0;
        M_AXI_ARADDR  = '0;
        M_AXI_RREADY  = 1'b0;

        case (state_q)
            ST_IDLE: begin
                if (start) begin
                    snap_load = 1'b1;
                    error_d   = 1'b0;
                    err_idx_d = '0;
                    idx_d     = '0;
                    aw_done_d = 1'b0;
                    w_done_d  = 1'b0;
                    state_d   = ST_WR_REQ;
                end
            end
            ST_WR_REQ: begin
                // Address and data channels complete independently; each VALID
                // drops once its own handshake is recorded.
                M_AXI_AWVALID = !aw_done_q;
                M_AXI_WVALID  = !w_done_q;
                M_AXI_AWADDR  = cur_addr;
                M_AXI_WDATA   = cur_word;
                M_AXI_WSTRB   = 4'hF;
                if (M_AXI_AWVALID && M_AXI_AWREADY) aw_done_d = 1'b1;
                if (M_AXI_WVALID && M_AXI_WREADY)   w_done_d  = 1'b1;
                if (aw_done_d && w_done_d) begin
                    aw_done_d = 1'b0;
                    w_done_d  = 1'b0;
                    state_d   = ST_WR_RESP;
                end
            end
            ST_WR_RESP: begin
                M_AXI_BREADY = 1'b1;
                if (M_AXI_BVALID) begin
                    fail = (M_AXI_BRESP != RESP_OKAY);
                    if (idx_q == LAST_IDX) begin
                        idx_d   = '0;
                        state_d = ST_RD_REQ;
                    end else begin
                        idx_d   = idx_q + 1'b1;
                        state_d = ST_WR_REQ;
                    end
                end
            end
            ST_RD_REQ: begin
                M_AXI_ARVALID = 1'b1;
                M_AXI_ARADDR  = cur_addr;
                if (M_AXI_ARREADY) state_d = ST_RD_RESP;
            end
            ST_RD_RESP: begin
                M_AXI_RREADY = 1'b1;
                if (M_AXI_RVALID) begin
                    fail = (M_AXI_RRESP != RESP_OKAY) || (M_AXI_RDATA != cur_word);
                    if (idx_q == LAST_IDX) begin
                        state_d = ST_FINISH;
                    end else begin
                        idx_d   = idx_q + 1'b1;
                        state_d = ST_RD_REQ;
                    end
                end
            end
            ST_FINISH: state_d = ST_IDLE;
            default:   state_d = ST_IDLE;
        endcase

        // Only the first failure of a run is recorded; later ones just keep error set.
        if (fail && !error_q) begin
            error_d   = 1'b1;
            err_idx_d = 8'(idx_q);
        end
    end

    assign busy         = (state_q != ST_IDLE) && (state_q != ST_FINISH);
    assign done         = (state_q == ST_FINISH);
    assign error        = error_q;
    assign err_index    = err_idx_q;
    assign M_AXI_AWPROT = 3'b000;
    assign M_AXI_ARPROT = 3'b000;

endmodule

// File: tb/tb_plc_seq_cfg_master.sv
// Randomized bench: a memory-backed AXI4-Lite slave with configurable ready
// latencies and fault injection, checked against a per-run expected outcome.
module tb_plc_seq_cfg_master;
    import plc_seq_cfg_pkg::*;

    localparam int N = 4;

    logic            ACLK = 1'b0;
    logic            ARESETN = 1'b0;
    logic            start = 1'b0;
    logic [N*32-1:0] cfg_data = '0;
    logic            busy, done, error;
    logic [7:0]      err_index;
    logic [31:0]     AWADDR, WDATA, ARADDR;
    logic [2:0]      AWPROT, ARPROT;
    logic [3:0]      WSTRB;
    logic            AWVALID, WVALID, BREADY, ARVALID, RREADY;
    logic            AWREADY = 1'b0, WREADY = 1'b0, BVALID = 1'b0, ARREADY = 1'b0, RVALID = 1'b0;
    logic [1:0]      BRESP = 2'b00, RRESP = 2'b00;
    logic [31:0]     RDATA = '0;

    always #5 ACLK = ~ACLK;

    plc_seq_cfg_master #(.NUM_REGS(N), .BASE_ADDR(32'h0), .C_M_AXI_ADDR_WIDTH(32)) dut (
        .ACLK(ACLK), .ARESETN(ARESETN), .start(start), .cfg_data(cfg_data),
        .busy(busy), .done(done), .error(error), .err_index(err_index),
        .M_AXI_AWADDR(AWADDR), .M_AXI_AWPROT(AWPROT), .M_AXI_AWVALID(AWVALID), .M_AXI_AWREADY(AWREADY),
        .M_AXI_WDATA(WDATA), .M_AXI_WSTRB(WSTRB), .M_AXI_WVALID(WVALID), .M_AXI_WREADY(WREADY),
        .M_AXI_BRESP(BRESP), .M_AXI_BVALID(BVALID), .M_AXI_BREADY(BREADY),
        .M_AXI_ARADDR(ARADDR), .M_AXI_ARPROT(ARPROT), .M_AXI_ARVALID(ARVALID), .M_AXI_ARREADY(ARREADY),
        .M_AXI_RDATA(RDATA), .M_AXI_RRESP(RRESP), .M_AXI_RVALID(RVALID), .M_AXI_RREADY(RREADY)
    );

    int n_cmp = 0, n_bad = 0;

    task automatic chk(input string tag, input logic [63:0] got, input logic [63:0] exp);
        n_cmp++;
        if (got !== exp) begin
            n_bad++;
            $display("FAIL %s: got %0h expected %0h", tag, got, exp);
        end
    endtask

    // slave configuration, written only by the main process
    int          mode = 3;       // 0 random, 1 W 3 cycles before AW, 2 AW/W same cycle, 3 zero-wait
    logic [N-1:0] bad_b = '0, bad_rresp = '0, bad_rdata = '0;

    // slave state, written only by the slave process
    logic [31:0] aw_log[$], w_log[$], ar_log[$];
    logic [31:0] mem [N];
    int          done_cnt = 0, viol = 0;
    int          aw_wait, w_wait, ar_wait, aw_lat, w_lat, ar_lat, b_due, r_due;
    bit          aw_got, w_got, pv_aw, pv_w, pv_ar;
    logic [31:0] pa_aw, pd_w, pa_ar, b_addr, b_data, r_addr;
    logic [1:0]  b_resp;

    function automatic int lat_aw();
        case (mode) 1: return 3; 2: return 1; 3: return 0; default: return $urandom_range(0, 3); endcase
    endfunction
    function automatic int lat_w();
        case (mode) 1: return 0; 2: return 1; 3: return 0; default: return $urandom_range(0, 3); endcase
    endfunction
    function automatic int lat_rsp();
        return (mode == 0) ? $urandom_range(0, 3) : 0;
    endfunction

    always @(posedge ACLK) begin
        if (!ARESETN) begin
            aw_got = 0; w_got = 0; pv_aw = 0; pv_w = 0; pv_ar = 0;
            aw_wait = 0; w_wait = 0; ar_wait = 0; b_due = -1; r_due = -1;
            aw_lat = lat_aw(); w_lat = lat_w(); ar_lat = lat_aw();
            #1;
            AWREADY = 0; WREADY = 0; ARREADY = 0; BVALID = 0; RVALID = 0;
        end else begin
            bit b_fire, r_fire;
            // a VALID left waiting at the previous edge must persist unchanged
            if (pv_aw && (!AWVALID || AWADDR != pa_aw)) viol++;
            if (pv_w && (!WVALID || WDATA != pd_w)) viol++;
            if (pv_ar && (!ARVALID || ARADDR != pa_ar)) viol++;
            if (ARVALID && (AWVALID || WVALID || BREADY)) viol++;
            pv_aw = AWVALID && !AWREADY; pa_aw = AWADDR;
            pv_w  = WVALID && !WREADY;   pd_w  = WDATA;
            pv_ar = ARVALID && !ARREADY; pa_ar = ARADDR;
            if (AWVALID && AWREADY) begin
                aw_log.push_back(AWADDR); b_addr = AWADDR; aw_got = 1; aw_wait = 0; aw_lat = lat_aw();
            end
            if (WVALID && WREADY) begin
                w_log.push_back(WDATA); b_data = WDATA; w_got = 1; w_wait = 0; w_lat = lat_w();
            end
            if (ARVALID && ARREADY) begin
                ar_log.push_back(ARADDR); r_addr = ARADDR; ar_wait = 0; ar_lat = lat_aw(); r_due = lat_rsp();
            end
            b_fire = BVALID && BREADY;
            r_fire = RVALID && RREADY;
            if (done) done_cnt++;
            if (aw_got && w_got) begin
                aw_got = 0; w_got = 0;
                mem[b_addr[3:2]] = b_data;
                b_resp = bad_b[b_addr[3:2]] ? RESP_SLVERR : RESP_OKAY;
                b_due = lat_rsp();
            end
            #1;
            if (b_fire) BVALID = 0;
            if (r_fire) RVALID = 0;
            if (b_due == 0) begin
                BVALID = 1; BRESP = b_resp; b_due = -1;
            end else if (b_due > 0) b_due--;
            if (r_due == 0) begin
                RVALID = 1;
                RDATA = bad_rdata[r_addr[3:2]] ? ~mem[r_addr[3:2]] : mem[r_addr[3:2]];
                RRESP = bad_rresp[r_addr[3:2]] ? RESP_SLVERR : RESP_OKAY;
                r_due = -1;
            end else if (r_due > 0) r_due--;
            if (AWVALID) begin AWREADY = (aw_wait >= aw_lat); aw_wait++; end else AWREADY = 0;
            if (WVALID)  begin WREADY  = (w_wait  >= w_lat);  w_wait++;  end else WREADY  = 0;
            if (ARVALID) begin ARREADY = (ar_wait >= ar_lat); ar_wait++; end else ARREADY = 0;
        end
    end

    // Expected {error, err_index}: writes all precede reads, so the first
    // failing write wins, otherwise the first failing read.
    function automatic logic [8:0] exp_err();
        for (int i = 0; i < N; i++) if (bad_b[i]) return {1'b1, 8'(i)};
        for (int i = 0; i < N; i++) if (bad_rresp[i] || bad_rdata[i]) return {1'b1, 8'(i)};
        return 9'd0;
    endfunction

    task automatic run_seq(input logic [N*32-1:0] cfg, input string nm, input bit second_start, input int exp_lat);
        int a0, w0, r0, d0, v0, cyc;
        logic [8:0] e;
        a0 = aw_log.size(); w0 = w_log.size(); r0 = ar_log.size(); d0 = done_cnt; v0 = viol; cyc = 0;
        e = exp_err();
        @(negedge ACLK); cfg_data = cfg; start = 1;
        @(negedge ACLK); start = 0;
        chk({nm, ":busy_after_start"}, busy, 1);
        while (!done && cyc < 2000) begin
            if (second_start && cyc == 3) begin cfg_data = ~cfg; start = 1; end
            else start = 0;
            @(negedge ACLK); cyc++;
        end
        start = 0;
        chk({nm, ":done_seen"}, cyc < 2000, 1);
        if (exp_lat >= 0) chk({nm, ":latency"}, cyc, exp_lat);
        chk({nm, ":busy_at_done"}, busy, 0);
        chk({nm, ":error"}, error, e[8]);
        chk({nm, ":err_index"}, err_index, e[7:0]);
        @(negedge ACLK);
        chk({nm, ":done_one_cycle"}, done, 0);
        chk({nm, ":done_count"}, done_cnt - d0, 1);
        chk({nm, ":n_aw"}, aw_log.size() - a0, N);
        chk({nm, ":n_w"}, w_log.size() - w0, N);
        chk({nm, ":n_ar"}, ar_log.size() - r0, N);
        chk({nm, ":protocol"}, viol - v0, 0);
        chk({nm, ":error_hold"}, {error, err_index}, e);
        if (aw_log.size() >= a0 + N && w_log.size() >= w0 + N && ar_log.size() >= r0 + N)
            for (int i = 0; i < N; i++) begin
                chk($sformatf("%s:awaddr%0d", nm, i), aw_log[a0+i], 32'(4*i));
                chk($sformatf("%s:wdata%0d", nm, i), w_log[w0+i], cfg[32*i +: 32]);
                chk($sformatf("%s:araddr%0d", nm, i), ar_log[r0+i], 32'(4*i));
            end
    endtask

    initial begin
        logic [N*32-1:0] base_cfg;
        int k, a0;
        base_cfg = {32'd4, 32'd3, 32'd2, 32'd1};
        repeat (3) @(negedge ACLK);
        chk("rst:busy", busy, 0);
        chk("rst:done", done, 0);
        chk("rst:err", {error, err_index}, 0);
        chk("rst:valids", {AWVALID, WVALID, ARVALID, BREADY, RREADY}, 0);
        chk("rst:addr", {AWADDR, ARADDR, WDATA}, 0);
        ARESETN = 1;
        @(negedge ACLK);

        mode = 3;
        run_seq(base_cfg, "basic", 0, 4 * N);

        bad_rdata = 4'b0100;
        run_seq(base_cfg, "rd_mismatch", 0, 4 * N);

        bad_b = 4'b0010; bad_rdata = 4'b1000;
        run_seq(base_cfg, "bresp_and_rd", 0, -1);
        bad_b = '0; bad_rdata = '0;

        mode = 1;
        run_seq({$urandom, $urandom, $urandom, $urandom}, "w_early", 0, -1);
        mode = 2;
        run_seq({$urandom, $urandom, $urandom, $urandom}, "aw_w_same", 0, -1);

        mode = 0;
        run_seq({$urandom, $urandom, $urandom, $urandom}, "second_start", 1, -1);

        // asynchronous reset in the middle of a write request
        mode = 1;
        @(negedge ACLK); cfg_data = base_cfg; start = 1;
        @(negedge ACLK); start = 0;
        k = 0;
        while (!AWVALID && k < 50) begin @(negedge ACLK); k++; end
        chk("arst:awvalid_seen", k < 50, 1);
        ARESETN = 0;
        #1;
        chk("arst:valids_low", {AWVALID, WVALID, ARVALID}, 0);
        chk("arst:busy", busy, 0);
        repeat (2) @(negedge ACLK);
        ARESETN = 1;
        a0 = aw_log.size();
        repeat (10) @(negedge ACLK);
        chk("arst:no_activity", {busy, AWVALID, WVALID, ARVALID}, 0);
        chk("arst:no_new_aw", aw_log.size() - a0, 0);
        chk("arst:no_report", {done, error}, 0);
        mode = 0;
        run_seq(base_cfg, "after_reset", 0, -1);

        for (int t = 0; t < 20; t++) begin
            mode      = 0;
            bad_b     = ($urandom_range(0, 2) == 0) ? 4'($urandom) : 4'h0;
            bad_rresp = ($urandom_range(0, 3) == 0) ? 4'($urandom) : 4'h0;
            bad_rdata = ($urandom_range(0, 2) == 0) ? 4'($urandom) : 4'h0;
            run_seq({$urandom, $urandom, $urandom, $urandom}, $sformatf("rnd%0d", t), 0, -1);
        end

        $display("*** SUMMARY: %0d compared / %0d mismatched ***", n_cmp, n_bad);
        $finish;
    end

endmodule
